alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_seq_muldiv.sv | 80 ++++++++
 rtl/alu_seq.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Opcode constants and controller state type for the sequential ALU.
// Meant to be shared with any control unit that issues ALU operations.
package alu_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_MUL  = 3'b011;
  localparam logic [2:0] OP_DIVU = 3'b100;
  localparam logic [2:0] OP_REMU = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_SLT  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_e;

  function automatic logic is_multi_cycle(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIVU) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative datapath: shift-add multiply (LSB first) and restoring unsigned
// divide (MSB first), one bit per step, WIDTH steps per operation.
module alu_seq_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_next_o,
  output logic             last_o
);

  localparam int CW = $clog2(WIDTH);

  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   trial;
  logic             q_bit;

  // acc is the product accumulator for MUL and the partial remainder for
  // DIVU/REMU; a shifts left in both cases (multiplicand / dividend->quotient).
  always_comb begin
    op_d   = op_q;
    acc_d  = acc_q;
    a_d    = a_q;
    b_d    = b_q;
    cnt_d  = cnt_q;
    rem_sh = {acc_q, a_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, b_q};
    q_bit  = ~trial[WIDTH];
    if (load_i) begin
      op_d  = op_i;
      acc_d = '0;
      a_d   = a_i;
      b_d   = b_i;
      cnt_d = '0;
    end else if (step_i) begin
      cnt_d = cnt_q + 1'b1;
      if (op_q == OP_MUL) begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d = a_q << 1;
        b_d = b_q >> 1;
      end else begin
        // With a zero divisor every trial succeeds, giving all-ones and rem=A.
        acc_d = q_bit ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        a_d   = {a_q[WIDTH-2:0], q_bit};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= OP_MUL;
      acc_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      op_q  <= op_d;
      acc_q <= acc_d;
      a_q   <= a_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  assign res_next_o = (op_q == OP_DIVU) ? a_d : acc_d;
  assign last_o     = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle logic/add/sub/slt plus iterative mul/div.
// Define ALU_SEQ_OVF_EN to add the registered signed-overflow output ovf.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       aluOP,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] bus_resultOP,
  output logic             zero,
`ifdef ALU_SEQ_OVF_EN
  output logic             ovf,
`endif
  output alu_state_e       state_o
);

  // Handshake: an op is accepted when start=1 while state is IDLE; done is a
  // one-cycle pulse with bus_resultOP valid; start is ignored while busy.
  alu_state_e       state_q, state_d;
  logic             accept;
  logic             multi;
  logic [WIDTH-1:0] sum, diff, single_res;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic [WIDTH-1:0] md_res;
  logic             md_last;

  assign accept = start && (state_q == ST_IDLE);
  assign multi  = is_multi_cycle(aluOP);
  assign sum    = A + B;
  assign diff   = A - B;

  always_comb begin
    single_res = '0;
    case (aluOP)
      OP_AND:  single_res = A & B;
      OP_OR:   single_res = A | B;
      OP_ADD:  single_res = sum;
      OP_SUB:  single_res = diff;
      OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      default: single_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = multi ? ST_CALC : ST_DONE;
      ST_CALC: if (md_last) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_CALC) || (state_q == ST_DONE);
    done = (state_q == ST_DONE);
  end

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk        (clk),
    .rst        (rst),
    .load_i     (accept && multi),
    .step_i     (state_q == ST_CALC),
    .op_i       (aluOP),
    .a_i        (A),
    .b_i        (B),
    .res_next_o (md_res),
    .last_o     (md_last)
  );

  // Result registers load on the edge that enters DONE, so they change
  // exactly when done rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_q  <= '0;
      zero_q <= 1'b1;
    end else if (accept && !multi) begin
      res_q  <= single_res;
      zero_q <= (single_res == '0);
    end else if ((state_q == ST_CALC) && md_last) begin
      res_q  <= md_res;
      zero_q <= (md_res == '0);
    end
  end

`ifdef ALU_SEQ_OVF_EN
  logic ovf_q;
  logic ovf_calc;

  always_comb begin
    ovf_calc = 1'b0;
    if (aluOP == OP_ADD)
      ovf_calc = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
    else if (aluOP == OP_SUB)
      ovf_calc = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
  end

  always_ff @(posedge clk) begin
    if (rst)                                  ovf_q <= 1'b0;
    else if (accept && !multi)                ovf_q <= ovf_calc;
    else if ((state_q == ST_CALC) && md_last) ovf_q <= 1'b0;
  end

  assign ovf = ovf_q;
`endif

  assign bus_resultOP = res_q;
  assign zero         = zero_q;
  assign state_o      = state_q;

endmodule
